// File: rtl/sphere_hit_scan_pkg.sv
// Shared types and helpers for the sphere collision scanner.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package sphere_hit_scan_pkg;

  typedef logic [63:0]      fixed_real;
  typedef logic [2:0][63:0] vector;
  typedef logic [2:0][7:0]  color;

  localparam int FRAC_BITS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  // Clamp a signed 32-bit integer distance into a symmetric signed 16-bit range.
  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767) begin
      return 16'sh7fff;
    end else if (v < -32'sd32767) begin
      return 16'sh8001;
    end else begin
      return v[15:0];
    end
  endfunction

endpackage

// File: rtl/sphere_hit_scan_dist_pipe.sv
// Distance pipeline: per-axis difference (saturated), square, sum and compare with radius squared.
// Latency: two register stages; the compare result is combinational off the second stage.
// Backpressure: none; one sample per cycle, Flush drops everything in flight.
module hit_dist_pipe
  import sphere_hit_scan_pkg::*;
#(
  parameter logic [33:0] RADIUS_SQ = 34'd40000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Flush,
  input  logic       In_vld,
  input  logic [1:0] In_index,
  input  vector      In_pos,
  input  vector      Paddle,
  output logic       Out_vld,
  output logic [1:0] Out_index,
  output logic       Out_hit
);

  logic [2:0]         borrow;
  logic signed [31:0] d_int [3];
  logic signed [15:0] s1_d  [3];
  logic               s1_vld;
  logic [1:0]         s1_idx;
  logic [31:0]        s2_sq [3];
  logic               s2_vld;
  logic [1:0]         s2_idx;
  logic [33:0]        sum;

  // Integer part of the full 64-bit difference: subtract the high words and take the borrow out of the fractions.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      borrow[k] = In_pos[k][FRAC_BITS-1:0] < Paddle[k][FRAC_BITS-1:0];
      d_int[k]  = $signed(In_pos[k][FRAC_BITS +: 32] - Paddle[k][FRAC_BITS +: 32] - {31'b0, borrow[k]});
    end
  end

  // S1: register saturated per-axis distances with their tag.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s1_vld <= 1'b0;
      s1_idx <= 2'd0;
      for (int k = 0; k < 3; k++) s1_d[k] <= '0;
    end else begin
      s1_vld <= In_vld & ~Flush;
      s1_idx <= In_index;
      for (int k = 0; k < 3; k++) s1_d[k] <= sat16(d_int[k]);
    end
  end

  // S2: register per-axis squares; |d| <= 32767 so the square always fits in 32 bits.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      s2_vld <= 1'b0;
      s2_idx <= 2'd0;
      for (int k = 0; k < 3; k++) s2_sq[k] <= '0;
    end else begin
      s2_vld <= s1_vld & ~Flush;
      s2_idx <= s1_idx;
      for (int k = 0; k < 3; k++) s2_sq[k] <= 32'(s1_d[k]) * 32'(s1_d[k]);
    end
  end

  // S3: sum of squares against the strict radius bound; the caller's hit latch is the S3 register.
  always_comb begin
    sum       = 34'(s2_sq[0]) + 34'(s2_sq[1]) + 34'(s2_sq[2]);
    Out_hit   = sum < RADIUS_SQ;
    Out_vld   = s2_vld;
    Out_index = s2_idx;
  end

endmodule

// File: rtl/sphere_hit_scan.sv
// Per-frame collision scan of four spheres against the paddle, plus score and lives keeping.
// Latency: frame edge E -> Read_index sweep E+1..E+4, hit for sphere i visible at E+i+5, Scan_done at E+9.
// Backpressure: none; a frame edge at any point aborts and restarts the scan.
module sphere_hit_scan
  import sphere_hit_scan_pkg::*;
#(
  parameter int         HIT_RADIUS = 200,
  parameter logic [2:0] LIVES_INIT = 3'd3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Frame_Clk,
  input  vector       Paddle_pos,
  input  vector       Sphere_pos,
  input  logic [1:0]  curr_index,
  input  logic [3:0]  dropped,
  output logic [1:0]  Read_index,
  output logic        Hit,
  output logic [1:0]  Hit_index,
  output logic        Scan_done,
  output logic [15:0] Score,
  output logic [2:0]  Lives,
  output logic        Game_over
);

  localparam logic [33:0] RADIUS_SQ = 34'(HIT_RADIUS * HIT_RADIUS);

  scan_state_t state, state_nxt;
  logic [1:0]  rd_idx_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic        frame_old;
  logic        frame_edge;
  logic        rd_vld;
  vector       paddle_q;
  logic        p_vld, p_hit;
  logic [1:0]  p_idx;
  logic [2:0]  drop_cnt, lives_nxt;

  assign frame_edge = Frame_Clk & ~frame_old;
  assign Scan_done  = (state == DONE);

  // Frame level history; resets high so a high Frame_Clk at release is not an edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) frame_old <= 1'b1;
    else          frame_old <= Frame_Clk;
  end

  // Next-state: a frame edge restarts the scan from any state.
  always_comb begin
    state_nxt  = state;
    rd_idx_nxt = Read_index;
    cnt_nxt    = cnt;
    if (frame_edge) begin
      state_nxt  = SCAN;
      rd_idx_nxt = 2'd0;
      cnt_nxt    = 2'd0;
    end else begin
      case (state)
        SCAN: begin
          if (Read_index == 2'd3) begin
            state_nxt = DRAIN;
            cnt_nxt   = 2'd0;
          end else begin
            rd_idx_nxt = Read_index + 2'd1;
          end
        end
        DRAIN: begin
          if (cnt == 2'd3) state_nxt = DONE;
          else             cnt_nxt   = cnt + 2'd1;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  // State register, read pointer and the paddle snapshot taken at the frame edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      Read_index <= 2'd0;
      cnt        <= 2'd0;
      rd_vld     <= 1'b0;
      paddle_q   <= '0;
    end else begin
      state      <= state_nxt;
      Read_index <= rd_idx_nxt;
      cnt        <= cnt_nxt;
      rd_vld     <= (state == SCAN) & ~frame_edge;
      if (frame_edge) paddle_q <= Paddle_pos;
    end
  end

  hit_dist_pipe #(
    .RADIUS_SQ (RADIUS_SQ)
  ) u_pipe (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Flush     (frame_edge),
    .In_vld    (rd_vld),
    .In_index  (curr_index),
    .In_pos    (Sphere_pos),
    .Paddle    (paddle_q),
    .Out_vld   (p_vld),
    .Out_index (p_idx),
    .Out_hit   (p_hit)
  );

  // Hit latch: first hit of a scan wins (lowest index, since indices arrive in order).
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Hit       <= 1'b0;
      Hit_index <= 2'd0;
    end else if (frame_edge) begin
      Hit       <= 1'b0;
      Hit_index <= 2'd0;
    end else if (p_vld && p_hit && !Hit) begin
      Hit       <= 1'b1;
      Hit_index <= p_idx;
    end
  end

  // Lives after this frame's drops, floored at zero.
  always_comb begin
    drop_cnt  = 3'(dropped[0]) + 3'(dropped[1]) + 3'(dropped[2]) + 3'(dropped[3]);
    lives_nxt = (drop_cnt >= Lives) ? 3'd0 : Lives - drop_cnt;
  end

  // Score and lives bookkeeping on the frame edge, while Hit still shows last frame's result.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Score     <= 16'd0;
      Lives     <= LIVES_INIT;
      Game_over <= (LIVES_INIT == 3'd0);
    end else if (frame_edge) begin
      if (Hit && !Game_over) Score <= Score + 16'd1;
      Lives <= lives_nxt;
      if (lives_nxt == 3'd0) Game_over <= 1'b1;
    end
  end

endmodule
